// File: rtl/mem_stage_pkg.sv
// Shared CPU pipeline definitions: EX->MEM and MEM->WB bus layouts,
// field offsets, load-type codes and the MEM-stage load FSM states.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_W   = 74;
  localparam int MS_TO_WS_BUS_W   = 70;

  localparam int PC_LSB           = 0;
  localparam int ALU_RESULT_LSB   = 32;
  localparam int DEST_LSB         = 64;
  localparam int GR_WE_BIT        = 69;
  localparam int LD_TYPE_LSB      = 70;
  localparam int RES_FROM_MEM_BIT = 73;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_type_e;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_WAIT = 2'd1,
    LS_HAVE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the byte/half lane from the addressed word
// and sign- or zero-extends it according to the load type.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] v);
    return {24'd0, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = addr[1] ? word[31:16] : word[15:0];

    // Unlisted codes fall through to the full word.
    case (ld_type)
      LD_B:    result = sext8(lane_b);
      LD_H:    result = sext16(lane_h);
      LD_BU:   result = zext8(lane_b);
      LD_HU:   result = zext16(lane_h);
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one instruction slot with valid/allowin handshake,
// load-data wait/buffer FSM, load alignment and forwarding to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ws_allowin,
  output logic                      ms_allowin,
  input  logic                      es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
  input  logic                      data_sram_data_ok,
  input  logic [31:0]               data_sram_rdata,
  output logic                      ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
  output logic [4:0]                ms_to_ds_dest,
  output logic [31:0]               ms_to_ds_value,
  output logic                      ms_to_ds_load_pending
);

  logic                      ms_vld_p0;
  logic [ES_TO_MS_BUS_W-1:0] ms_bus_p0;
  logic                      buf_vld_p0;
  logic [31:0]               rdata_buf_p0;
  ld_state_e                 state_p0;
  ld_state_e                 state_nxt;

  logic        res_from_mem;
  logic [2:0]  ld_type;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        ms_ready_go;
  logic        buf_capture;
  logic [31:0] ld_word;
  logic [31:0] ld_result;
  logic [31:0] final_result;

  assign res_from_mem = ms_bus_p0[RES_FROM_MEM_BIT];
  assign ld_type      = ms_bus_p0[LD_TYPE_LSB +: 3];
  assign gr_we        = ms_bus_p0[GR_WE_BIT];
  assign dest         = ms_bus_p0[DEST_LSB +: 5];
  assign alu_result   = ms_bus_p0[ALU_RESULT_LSB +: 32];
  assign pc           = ms_bus_p0[PC_LSB +: 32];

  // data_ok only counts for a load still waiting; stray pulses are dropped.
  assign ms_ready_go    = !res_from_mem || buf_vld_p0
                        || (state_p0 == LS_WAIT && data_sram_data_ok);
  assign ms_allowin     = !ms_vld_p0 || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_vld_p0 && ms_ready_go;
  assign buf_capture    = (state_p0 == LS_WAIT) && data_sram_data_ok && !ms_allowin;

  always_comb begin
    state_nxt = state_p0;
    if (ms_allowin) begin
      state_nxt = (es_to_ms_valid && es_to_ms_bus[RES_FROM_MEM_BIT]) ? LS_WAIT : LS_IDLE;
    end else if (buf_capture) begin
      state_nxt = LS_HAVE;
    end
  end

  // Stage p0: control state, asynchronously cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_vld_p0  <= 1'b0;
      buf_vld_p0 <= 1'b0;
      state_p0   <= LS_IDLE;
    end else begin
      state_p0 <= state_nxt;
      if (ms_allowin) begin
        ms_vld_p0  <= es_to_ms_valid;
        buf_vld_p0 <= 1'b0;
      end else if (buf_capture) begin
        buf_vld_p0 <= 1'b1;
      end
    end
  end

  // Stage p0: datapath registers, no reset needed.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus_p0 <= es_to_ms_bus;
    end
    if (buf_capture) begin
      rdata_buf_p0 <= data_sram_rdata;
    end
  end

  assign ld_word = buf_vld_p0 ? rdata_buf_p0 : data_sram_rdata;

  mem_load_align u_load_align (
    .word    (ld_word),
    .addr    (alu_result[1:0]),
    .ld_type (ld_type),
    .result  (ld_result)
  );

  assign final_result = res_from_mem ? ld_result : alu_result;
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  assign ms_to_ds_dest         = (ms_vld_p0 && gr_we) ? dest : 5'd0;
  assign ms_to_ds_value        = (ms_vld_p0 && gr_we) ? final_result : 32'd0;
  assign ms_to_ds_load_pending = ms_vld_p0 && res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/ALU vectors, pipeline
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_value;
  logic        ms_to_ds_load_pending;

  mem_stage dut (
    .clk                   (clk),
    .resetn                (resetn),
    .ws_allowin            (ws_allowin),
    .ms_allowin            (ms_allowin),
    .es_to_ms_valid        (es_to_ms_valid),
    .es_to_ms_bus          (es_to_ms_bus),
    .data_sram_data_ok     (data_sram_data_ok),
    .data_sram_rdata       (data_sram_rdata),
    .ms_to_ws_valid        (ms_to_ws_valid),
    .ms_to_ws_bus          (ms_to_ws_bus),
    .ms_to_ds_dest         (ms_to_ds_dest),
    .ms_to_ds_value        (ms_to_ds_value),
    .ms_to_ds_load_pending (ms_to_ds_load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ld;
    logic [2:0]  lt;
    logic [1:0]  addr;
    logic [31:0] rdata;
    int          dly;
    int          stall;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  bit          m_occ;
  bit          m_have;
  logic [73:0] m_ins;
  logic [31:0] m_hword;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [73:0] mk_bus(input bit ld, input logic [2:0] lt, input bit we,
                                         input logic [4:0] d, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {ld, lt, we, d, alu, pc};
  endfunction

  // Reference load extraction from shifts, masks and range tests.
  function automatic logic [31:0] ref_ld(input logic [31:0] word, input logic [1:0] addr,
                                         input logic [2:0] lt);
    logic [31:0] b;
    logic [31:0] h;
    int sb;
    int sh;
    sb = 8 * int'(addr);
    sh = 16 * int'(addr[1]);
    b = (word >> sb) & 32'h0000_00FF;
    h = (word >> sh) & 32'h0000_FFFF;
    case (lt)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_allowin"}, 96'(ms_allowin), 96'(1));
    chk({tag, "_tows_valid"}, 96'(ms_to_ws_valid), 96'(0));
    chk({tag, "_ds"}, 96'({ms_to_ds_dest, ms_to_ds_value}), 96'(0));
    chk({tag, "_pending"}, 96'(ms_to_ds_load_pending), 96'(0));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] alu;
    logic [31:0] pc;
    logic [69:0] exp_bus;
    alu = v.ld ? {30'h2000_0000, v.addr} : v.exp;
    pc  = 32'h1C00_0000 + 32'(idx * 4);
    exp_bus = {1'b1, 5'(idx + 1), v.exp, pc};
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(v.ld, v.lt, 1'b1, 5'(idx + 1), alu, pc);
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    #1 chk($sformatf("v%0d_entry_allowin", idx), 96'(ms_allowin), 96'(1));
    tick();
    es_to_ms_valid = 1'b0;
    if (v.ld) begin
      for (int k = 0; k < v.dly; k++) begin
        data_sram_rdata = $urandom;
        #1 chk($sformatf("v%0d_wait_pending", idx),
               96'({ms_to_ds_load_pending, ms_to_ws_valid}), 96'(2'b10));
        tick();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata = v.rdata;
      ws_allowin = (v.stall == 0);
      #1 chk($sformatf("v%0d_ok_bus", idx), 96'({ms_to_ws_valid, ms_to_ws_bus}), 96'({1'b1, exp_bus}));
      chk($sformatf("v%0d_ok_pending", idx), 96'(ms_to_ds_load_pending), 96'(0));
      for (int k = 1; k < v.stall; k++) begin
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = $urandom;
        #1 chk($sformatf("v%0d_stall", idx),
               96'({ms_allowin, ms_to_ws_valid, ms_to_ws_bus}), 96'({2'b01, exp_bus}));
      end
      if (v.stall > 0) begin
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = $urandom;
        ws_allowin = 1'b1;
        #1 chk($sformatf("v%0d_release", idx),
               96'({ms_allowin, ms_to_ws_valid, ms_to_ws_bus}), 96'({2'b11, exp_bus}));
      end
    end else begin
      #1 chk($sformatf("v%0d_alu_bus", idx), 96'({ms_to_ws_valid, ms_to_ws_bus}), 96'({1'b1, exp_bus}));
    end
    chk($sformatf("v%0d_fwd", idx), 96'({ms_to_ds_dest, ms_to_ds_value}), 96'({5'(idx + 1), v.exp}));
    tick();
    data_sram_data_ok = 1'b0;
    #1 chk($sformatf("v%0d_drained", idx), 96'({ms_to_ws_valid, ms_allowin}), 96'(2'b01));
  endtask

  initial begin
    resetn = 1'b0;
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    m_ins = '0;
    m_hword = '0;
    m_occ = 1'b0;
    m_have = 1'b0;

    vecs[0] = '{1'b0, 3'b000, 2'b00, 32'h0,          0, 0, 32'h0000_1234};
    vecs[1] = '{1'b1, 3'b000, 2'b01, 32'h0000_8000,  2, 0, 32'hFFFF_FF80};
    vecs[2] = '{1'b1, 3'b101, 2'b10, 32'hBEEF_0000,  1, 3, 32'h0000_BEEF};
    vecs[3] = '{1'b1, 3'b010, 2'b00, 32'hDEAD_BEEF,  0, 0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 3'b100, 2'b11, 32'h9A00_0000,  1, 0, 32'h0000_009A};
    vecs[5] = '{1'b1, 3'b001, 2'b00, 32'h1234_8765,  0, 1, 32'hFFFF_8765};
    vecs[6] = '{1'b1, 3'b000, 2'b00, 32'h0000_007F,  3, 0, 32'h0000_007F};
    vecs[7] = '{1'b1, 3'b001, 2'b10, 32'h7FFF_0000,  0, 2, 32'h0000_7FFF};
    vecs[8] = '{1'b1, 3'b011, 2'b01, 32'hCAFE_F00D,  1, 0, 32'hCAFE_F00D};
    vecs[9] = '{1'b1, 3'b100, 2'b10, 32'h00AB_0000,  0, 0, 32'h0000_00AB};

    #1 check_idle("reset");
    @(negedge clk);
    tick();
    resetn = 1'b1;
    #1 check_idle("post_reset");
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back ALU instructions: one per cycle, no bubble.
    ws_allowin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(1'b0, 3'b000, 1'b1, 5'(i + 3), 32'(100 + i), 32'h2000 + 32'(4 * i));
      #1 chk("b2b_allowin", 96'(ms_allowin), 96'(1));
      if (i > 0)
        chk("b2b_out", 96'({ms_to_ws_valid, ms_to_ws_bus[63:0]}),
            96'({1'b1, 32'(100 + i - 1), 32'h2000 + 32'(4 * (i - 1))}));
      tick();
    end
    es_to_ms_valid = 1'b0;
    #1 chk("b2b_last", 96'({ms_to_ws_valid, ms_to_ws_bus[31:0]}), 96'({1'b1, 32'h2014}));
    tick();

    // Randomized traffic against the transaction model.
    resetn = 1'b0;
    #1 resetn = 1'b1;
    m_occ = 1'b0;
    m_have = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit          ld;
      bit          rdy;
      bit          exp_allow;
      bit          exp_tows;
      logic [31:0] word;
      logic [31:0] fr;
      es_to_ms_valid = ($urandom_range(0, 3) != 0);
      es_to_ms_bus = mk_bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
      ws_allowin = ($urandom_range(0, 3) != 0);
      data_sram_rdata = $urandom;
      data_sram_data_ok = m_occ && m_ins[73] && !m_have && ($urandom_range(0, 2) == 0);
      #1;
      ld = m_ins[73];
      rdy = !ld || data_sram_data_ok || m_have;
      exp_allow = !m_occ || (rdy && ws_allowin);
      exp_tows = m_occ && rdy;
      word = m_have ? m_hword : data_sram_rdata;
      fr = ld ? ref_ld(word, m_ins[33:32], m_ins[72:70]) : m_ins[63:32];
      chk("rnd_handshake", 96'({ms_allowin, ms_to_ws_valid, ms_to_ds_load_pending}),
          96'({exp_allow, exp_tows, m_occ && ld && !rdy}));
      if (exp_tows)
        chk("rnd_bus", 96'(ms_to_ws_bus), 96'({m_ins[69], m_ins[68:64], fr, m_ins[31:0]}));
      chk("rnd_fwd", 96'({ms_to_ds_dest, ms_to_ds_value}),
          96'((m_occ && m_ins[69]) ? {m_ins[68:64], fr} : 37'd0));
      if (m_occ && ld && !m_have && data_sram_data_ok && !ws_allowin) begin
        m_have = 1'b1;
        m_hword = data_sram_rdata;
      end
      if (exp_allow) begin
        m_occ = es_to_ms_valid;
        m_have = 1'b0;
        if (es_to_ms_valid) m_ins = es_to_ms_bus;
      end
      tick();
    end

    // Reset while a load waits; a later data_ok must be ignored.
    resetn = 1'b0;
    #1 resetn = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 3'b010, 1'b1, 5'd9, 32'h0000_0040, 32'h3000);
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    tick();
    es_to_ms_valid = 1'b0;
    #1 chk("rst_mid_pending", 96'(ms_to_ds_load_pending), 96'(1));
    #2 resetn = 1'b0;
    #1 check_idle("rst_mid_async");
    tick();
    resetn = 1'b1;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5555_AAAA;
    #1 check_idle("rst_stray_ok");
    tick();
    data_sram_data_ok = 1'b0;
    #1 check_idle("rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed below.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 ws_allowin  in  1  WB can accept this cycle.
REQ-005 ms_allowin  out  1  MEM can accept from EX this cycle.
REQ-006 es_to_ms_valid  in  1  EX presents a valid inst.
REQ-007 es_to_ms_bus  in  74  {res_from_mem[73], ld_type[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-008 data_sram_data_ok  in  1  load read data returned this cycle (one pulse per issued load).
REQ-009 data_sram_rdata  in  32  load read word, valid with data_ok.
REQ-010 ms_to_ws_valid  out  1  valid inst offered to WB.
REQ-011 ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-012 ms_to_ds_dest  out  5  dest of valid reg-writing inst in MEM, else 0.
REQ-013 ms_to_ds_value  out  32  final_result under same qualification, else 0.
REQ-014 ms_to_ds_load_pending  out  1  valid load in MEM whose data not yet returned.

Function
REQ-015 SHALL hold one pipeline slot: ms_valid flag plus 74-bit bus register.
REQ-016 ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin).
REQ-017 On ms_allowin, ms_valid SHALL load es_to_ms_valid; bus register SHALL load only when es_to_ms_valid && ms_allowin.
REQ-018 ms_to_ws_valid SHALL equal ms_valid && ms_ready_go.
REQ-019 ms_ready_go SHALL be 1 for non-loads; for loads SHALL be 1 when data_ok is high this cycle or load data is already buffered.
REQ-020 Load FSM per slot: WAIT (load entered, no data) -> HAVE (data_ok seen, ws_allowin low) -> IDLE on handoff; WAIT -> IDLE directly when data_ok && ws_allowin.
REQ-021 In HAVE, data_sram_rdata SHALL be captured into a 32-bit buffer; later data_ok pulses with no load in WAIT SHALL be ignored.
REQ-022 New inst entering MEM SHALL clear buffer-valid flag in the same edge.
REQ-023 Load word source SHALL be buffer when buffered, else live data_sram_rdata.
REQ-024 Byte/half lane SHALL be selected by alu_result[1:0] (byte) / alu_result[1] (half), little-endian.
REQ-025 ld_type: 000 ld.b sign-ext, 001 ld.h sign-ext, 010 ld.w, 100 ld.bu zero-ext, 101 ld.hu zero-ext; other codes SHALL produce the full word.
REQ-026 final_result SHALL be the extended load value when res_from_mem, else alu_result.
REQ-027 ms_to_ds_dest/value SHALL be zero unless ms_valid && gr_we; value SHALL be final_result.
REQ-028 ms_to_ds_load_pending SHALL equal ms_valid && res_from_mem && !ms_ready_go.
REQ-029 Latency: non-load inst SHALL be offered to WB the cycle after entry; load offered in the data_ok cycle at earliest.
REQ-030 Simultaneous handoff to WB and entry from EX SHALL occur in one edge with no bubble.

Reset
REQ-031 On resetn low, ms_valid, buffer-valid flag and FSM SHALL clear asynchronously to 0/IDLE; bus and data buffers need no reset.
REQ-032 After reset: ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_dest=0, ms_to_ds_value=0, ms_to_ds_load_pending=0.
REQ-033 Reset mid-load SHALL discard the pending load; a data_ok arriving after release with no load in WAIT SHALL be ignored.

Structure
REQ-034 Bus widths (74, 70), field offsets and ld_type codes SHALL live in the shared CPU package/header used by all stages.
REQ-035 Load extraction SHALL be one combinational sub-module, mem_load_align (inputs word, addr[1:0], ld_type; output 32-bit result).

Verification
REQ-036 Non-load add, dest=5, alu_result=0x1234, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x1234,pc}, ms_to_ds_dest=5.
REQ-037 ld.b at addr ...01, rdata=0x00008000 with data_ok 2 cycles after entry -> load_pending=1 two cycles, then final_result=0xFFFFFF80.
REQ-038 ld.hu at addr ...10, rdata=0xBEEF0000, data_ok while ws_allowin=0 for 3 cycles -> data buffered, final_result=0x0000BEEF on release, ms_allowin=0 meanwhile.
REQ-039 Back-to-back non-loads with ws_allowin=1 -> one inst per cycle, no bubble, ms_allowin constant 1.
REQ-040 Assert resetn low while load in WAIT, release, pulse data_ok -> no ms_to_ws_valid, all outputs at reset values.
